booth_multiplier_param: RTL and testbench

- Self-contained sequential radix-2 Booth multiplier: control FSM, iteration counter and datapath in one block.
- Generalises the INIT/OPERATE/DONE multiplier controller with parametrised operand width and a per-operation signed/unsigned mode.
- Supports back-to-back restart from DONE without passing through INIT.
- Sits beside the ALU as a multi-cycle functional unit driven by a start/clear/done handshake.

---
 rtl/booth_multiplier_param.sv | 166 ++++++++++++++++
 tb/tb_booth_multiplier_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_param.sv
// ---------------------------------------------------------------------------
// booth_multiplier_param
// Sequential radix-2 Booth multiplier with start/clear/done handshake.
// One Booth step per OPERATE cycle, WIDTH+1 steps per operation, so latency
// is fixed regardless of operands or signed/unsigned mode.
//
// State table:
//   state   | meaning
//   INIT    | idle after reset/clear, waiting for op_start
//   OPERATE | Booth iterations in progress (op_busy=1)
//   DONE    | product valid on result (op_done=1), may restart directly
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   op_start     start request, sampled in INIT and DONE
//   op_clear     synchronous abort/clear, overrides op_start
//   op_signed    1 = two's-complement operands, latched at start
//   multiplicand operand A, latched at start
//   multiplier   operand B, latched at start
//   result       2*WIDTH-bit product, valid while op_done=1
//   op_busy      high in OPERATE
//   op_done      high in DONE
//   state        current state encoding
// ---------------------------------------------------------------------------
module booth_multiplier_param #(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic                 op_busy,
    output logic                 op_done,
    output logic [1:0]           state
);

    localparam logic [1:0] S_INIT    = 2'b00;
    localparam logic [1:0] S_OPERATE = 2'b01;
    localparam logic [1:0] S_DONE    = 2'b11;

    logic [1:0]         state_q,  state_d;
    logic [WIDTH+1:0]   acc_q,    acc_d;
    logic [WIDTH:0]     a_q,      a_d;
    logic [WIDTH:0]     mq_q,     mq_d;
    logic               qm1_q,    qm1_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [WIDTH+1:0]   a_ext;
    logic [WIDTH+1:0]   acc_sum;
    logic [WIDTH+1:0]   acc_sh;
    logic [WIDTH:0]     mq_sh;
    logic [2*WIDTH+2:0] prod_full;
    logic [WIDTH:0]     in_a_ext;
    logic [WIDTH:0]     in_b_ext;

    always_comb begin
        // Operands widened by one bit so unsigned values stay positive.
        in_a_ext = op_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
        in_b_ext = op_signed ? {multiplier[WIDTH-1], multiplier}     : {1'b0, multiplier};

        a_ext   = {a_q[WIDTH], a_q};
        acc_sum = acc_q;
        case ({mq_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + a_ext;
            2'b10:   acc_sum = acc_q - a_ext;
            default: acc_sum = acc_q;
        endcase

        // Arithmetic right shift of {acc, Q, q(-1)}.
        acc_sh    = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
        mq_sh     = {acc_sum[0], mq_q[WIDTH:1]};
        prod_full = {acc_sh, mq_sh};

        state_d  = state_q;
        acc_d    = acc_q;
        a_d      = a_q;
        mq_d     = mq_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_INIT, S_DONE: begin
                if (op_start) begin
                    state_d = S_OPERATE;
                    a_d     = in_a_ext;
                    mq_d    = in_b_ext;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_OPERATE: begin
                acc_d = acc_sh;
                mq_d  = mq_sh;
                qm1_d = mq_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d  = S_DONE;
                    result_d = prod_full[2*WIDTH-1:0];
                end
            end
            default: begin
                state_d  = S_INIT;
                acc_d    = '0;
                a_d      = '0;
                mq_d     = '0;
                qm1_d    = 1'b0;
                cnt_d    = '0;
                result_d = '0;
            end
        endcase

        if (op_clear) begin
            state_d  = S_INIT;
            acc_d    = '0;
            a_d      = '0;
            mq_d     = '0;
            qm1_d    = 1'b0;
            cnt_d    = '0;
            result_d = '0;
        end

        busy_d = (state_d == S_OPERATE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_INIT;
            acc_q    <= '0;
            a_q      <= '0;
            mq_q     <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            mq_q     <= mq_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result  = result_q;
    assign op_busy = busy_q;
    assign op_done = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_booth_multiplier_param.sv
module tb_booth_multiplier_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit instance
    logic        rst8, start8, clr8, s8;
    logic [7:0]  m8, b8;
    logic [15:0] res8;
    logic        busy8, done8;
    logic [1:0]  st8;

    // 64-bit (default) instance
    logic         rst64, start64, clr64, s64;
    logic [63:0]  m64, b64;
    logic [127:0] res64;
    logic         busy64, done64;
    logic [1:0]   st64;

    booth_multiplier_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .op_start(start8), .op_clear(clr8),
        .op_signed(s8), .multiplicand(m8), .multiplier(b8),
        .result(res8), .op_busy(busy8), .op_done(done8), .state(st8)
    );

    booth_multiplier_param dut64 (
        .clk(clk), .reset(rst64), .op_start(start64), .op_clear(clr64),
        .op_signed(s64), .multiplicand(m64), .multiplier(b64),
        .result(res64), .op_busy(busy64), .op_done(done64), .state(st64)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference products computed with plain integer arithmetic.
    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [127:0] ref64(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic signed [129:0] x, y, p;
        x = s ? 130'($signed(a)) : 130'({66'b0, a});
        y = s ? 130'($signed(b)) : 130'({66'b0, b});
        p = x * y;
        return p[127:0];
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
        logic [15:0] exp;
        int nb;
        exp = ref8(a, b, s);
        m8 = a; b8 = b; s8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        m8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        chk({tag, "_state_op"}, 128'(st8), 128'(2'b01));
        chk({tag, "_done_low"}, 128'(done8), 128'(0));
        nb = busy8 ? 1 : 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (busy8) nb++;
        end
        chk({tag, "_busy_cycles"}, 128'(nb), 128'(9));
        @(posedge clk); #1;
        chk({tag, "_state_done"}, 128'(st8), 128'(2'b11));
        chk({tag, "_done"}, 128'({done8, busy8}), 128'(2'b10));
        chk({tag, "_result"}, 128'(res8), 128'(exp));
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_hold"}, 128'({done8, res8}), 128'({1'b1, exp}));
    endtask

    task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic s, input string tag);
        logic [127:0] exp;
        int nb;
        exp = ref64(a, b, s);
        m64 = a; b64 = b; s64 = s; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        m64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        nb = busy64 ? 1 : 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            if (busy64) nb++;
        end
        chk({tag, "_busy_cycles"}, 128'(nb), 128'(65));
        @(posedge clk); #1;
        chk({tag, "_done"}, 128'({st64, done8 & 1'b0, done64}), 128'({2'b11, 1'b0, 1'b1}));
        chk({tag, "_result"}, res64, exp);
    endtask

    initial begin
        rst8 = 1'b1; start8 = 1'b0; clr8 = 1'b0; s8 = 1'b0; m8 = '0; b8 = '0;
        rst64 = 1'b1; start64 = 1'b0; clr64 = 1'b0; s64 = 1'b0; m64 = '0; b64 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset8", 128'({st8, busy8, done8, res8}), 128'(0));
        chk("reset64", {st64, busy64, done64, res64[123:0]}, 128'(0));
        rst8 = 1'b0; rst64 = 1'b0;
        @(posedge clk); #1;
        chk("idle8", 128'(st8), 128'(2'b00));

        // Directed cases
        run8(8'd200, 8'd150, 1'b0, "u200x150");
        chk("u200x150_abs", 128'(res8), 128'(16'd30000));
        run8(8'hF6, 8'd7, 1'b1, "s_m10x7");
        chk("s_m10x7_abs", 128'(res8), 128'(16'hFFBA));
        run8(8'h80, 8'h80, 1'b1, "s_minxmin");
        chk("s_minxmin_abs", 128'(res8), 128'(16'h4000));
        run8(8'hFF, 8'hFF, 1'b0, "u_ffxff");
        chk("u_ffxff_abs", 128'(res8), 128'(16'hFE01));
        run8(8'hFF, 8'hFF, 1'b1, "s_ffxff");
        chk("s_ffxff_abs", 128'(res8), 128'(16'h0001));

        // Abort on the 4th OPERATE cycle, started from DONE (result nonzero)
        m8 = 8'd9; b8 = 8'd11; s8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_state", 128'(st8), 128'(2'b01));
        clr8 = 1'b1;
        @(posedge clk); #1;
        clr8 = 1'b0;
        chk("abort_state", 128'(st8), 128'(2'b00));
        chk("abort_outs", 128'({busy8, done8, res8}), 128'(0));
        run8(8'd13, 8'd17, 1'b0, "after_abort");

        // Back-to-back restart from DONE
        run8(8'd3, 8'd5, 1'b0, "b2b");
        chk("b2b_abs", 128'(res8), 128'(16'd15));

        // start and clear together in DONE
        start8 = 1'b1; clr8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; clr8 = 1'b0;
        chk("startclr_state", 128'(st8), 128'(2'b00));
        chk("startclr_outs", 128'({busy8, done8, res8}), 128'(0));

        // Randomised operands in both modes
        for (int n = 0; n < 24; n++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
        end

        // Asynchronous reset between edges, mid-operation
        m8 = 8'd77; b8 = 8'd3; s8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #3;
        rst8 = 1'b1;
        #1;
        chk("async_rst_state", 128'(st8), 128'(2'b00));
        chk("async_rst_outs", 128'({busy8, done8, res8}), 128'(0));
        @(posedge clk); #1;
        rst8 = 1'b0;
        run8(8'd77, 8'd3, 1'b1, "after_rst");

        // Default width
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "w64_ones_u");
        chk("w64_ones_abs", res64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        run64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "w64_min_s");
        for (int n = 0; n < 4; n++) begin
            run64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), $sformatf("w64rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
